slot_arbiter: RTL and testbench

Time-slot round-robin arbiter that shares one resource among NUM_REQ requesters. Each grant lasts at most SLOT_LEN cycles, measured by an internal modulo slot counter. Early release is allowed, and one dead cycle separates consecutive grants. It sits in front of any shared datapath unit and sequences which requester drives it.

---
 rtl/slot_arbiter_pkg.sv | 9 +
 rtl/slot_arbiter_counter.sv | 46 ++++
 rtl/slot_arbiter.sv | 145 ++++++++++++++
 tb/tb_slot_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/slot_arbiter_pkg.sv
// Shared constants for the time-slot round-robin arbiter.
// State encodings are plain localparams so legacy tools can read them.
package slot_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/slot_arbiter_counter.sv
// Modulo slot counter with synchronous active-low reset, clear and enable.
// tc is high while the count sits on its last value (LIMIT-1).
module slot_counter #(
  parameter int CNT_W = 3,
  parameter int LIMIT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  assign tc    = (count_q == CNT_W'(LIMIT - 1));
  assign count = count_q;

  // next-count selection: clear beats enable, terminal count wraps to zero
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (en) begin
      if (tc) begin
        count_d = {CNT_W{1'b0}};
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/slot_arbiter.sv
// Time-slot round-robin arbiter: one owner at a time, each grant capped at
// SLOT_LEN cycles, early release allowed, one dead cycle between grants.
module slot_arbiter
  import slot_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int SLOT_LEN = 6,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   slot_count,
  output logic               slot_done,
  output logic               wrap_toggle
);

  logic [1:0]         state_d,     state_q;
  logic [NUM_REQ-1:0] grant_d,     grant_q;
  logic [ID_W-1:0]    grant_id_d,  grant_id_q;
  logic               busy_d,      busy_q;
  logic               slot_done_d, slot_done_q;
  logic               wrap_d,      wrap_q;
  logic [ID_W-1:0]    rr_ptr_d,    rr_ptr_q;

  logic               found_s;
  logic [ID_W-1:0]    win_id_s;
  logic [ID_W-1:0]    next_ptr_s;
  logic               owner_req_s;
  logic               tc_s;
  logic               cnt_clr_s;

  assign owner_req_s = req[grant_id_q];
  assign next_ptr_s  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                          : grant_id_q + ID_W'(1);
  // the counter only advances while the owner keeps its slot
  assign cnt_clr_s   = !((state_q == ST_GRANT) && !tc_s && owner_req_s);

  slot_counter #(
    .CNT_W (CNT_W),
    .LIMIT (SLOT_LEN)
  ) u_slot_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (1'b1),
    .count (slot_count),
    .tc    (tc_s)
  );

  // round-robin search from rr_ptr upward, wrapping modulo NUM_REQ
  always_comb begin
    found_s  = 1'b0;
    win_id_s = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found_s && req[cand]) begin
        found_s  = 1'b1;
        win_id_s = cand;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // FSM next-state: arbitration in IDLE/GAP, timeout before release in GRANT
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    busy_d      = busy_q;
    slot_done_d = 1'b0;
    wrap_d      = wrap_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (found_s) begin
          state_d    = ST_GRANT;
          grant_d    = NUM_REQ'(1) << win_id_s;
          grant_id_d = win_id_s;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
          grant_d = {NUM_REQ{1'b0}};
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (tc_s) begin
          state_d     = ST_GAP;
          grant_d     = {NUM_REQ{1'b0}};
          busy_d      = 1'b0;
          slot_done_d = 1'b1;
          wrap_d      = ~wrap_q;
          rr_ptr_d    = next_ptr_s;
        end else if (!owner_req_s) begin
          state_d  = ST_GAP;
          grant_d  = {NUM_REQ{1'b0}};
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr_s;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_REQ{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= {NUM_REQ{1'b0}};
      grant_id_q  <= {ID_W{1'b0}};
      busy_q      <= 1'b0;
      slot_done_q <= 1'b0;
      wrap_q      <= 1'b0;
      rr_ptr_q    <= {ID_W{1'b0}};
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      slot_done_q <= slot_done_d;
      wrap_q      <= wrap_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign slot_done   = slot_done_q;
  assign wrap_toggle = wrap_q;

endmodule

// File: tb/tb_slot_arbiter.sv
// Self-checking bench for slot_arbiter: directed scenarios then random req/reset,
// every cycle compared against a behavioural owner/slot model.
module tb_slot_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int SLOT_LEN = 6;
  localparam int CNT_W    = 3;

  logic               clk;
  logic               reset;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic [CNT_W-1:0]   slot_count;
  logic               slot_done;
  logic               wrap_toggle;

  int checks = 0;
  int errors = 0;

  // behavioural model: owner index (-1 = nobody), cycles used, next search start
  int m_owner = -1;
  int m_last  = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_done  = 0;
  int m_wrap  = 0;

  slot_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .SLOT_LEN(SLOT_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .slot_count (slot_count),
    .slot_done  (slot_done),
    .wrap_toggle(wrap_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [NUM_REQ-1:0] r, input logic rs);
    if (!rs) begin
      m_owner = -1; m_last = 0; m_cnt = 0; m_ptr = 0; m_done = 0; m_wrap = 0;
    end else begin
      m_done = 0;
      if (m_owner >= 0) begin
        if (m_cnt == SLOT_LEN - 1) begin
          m_done  = 1;
          m_wrap  = 1 - m_wrap;
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
          m_cnt   = 0;
        end else if (!r[m_owner]) begin
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          int j;
          j = (m_ptr + i) % NUM_REQ;
          if (m_owner < 0 && r[j]) begin
            m_owner = j;
            m_last  = j;
            m_cnt   = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [NUM_REQ-1:0] r, input logic rs);
    logic [31:0] exp_grant;
    req   = r;
    reset = rs;
    @(posedge clk);
    model_edge(r, rs);
    @(negedge clk);
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check_val("grant",       32'(grant),       exp_grant);
    check_val("grant_id",    32'(grant_id),    32'(m_last));
    check_val("busy",        32'(busy),        (m_owner >= 0) ? 32'd1 : 32'd0);
    check_val("slot_count",  32'(slot_count),  32'(m_cnt));
    check_val("slot_done",   32'(slot_done),   32'(m_done));
    check_val("wrap_toggle", 32'(wrap_toggle), 32'(m_wrap));
  endtask

  initial begin
    logic [NUM_REQ-1:0] r;
    logic               rs;
    req   = 4'b0000;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

    // single requester: timeout, gap, re-grant
    for (int i = 0; i < 16; i++) step(4'b0001, 1'b1);
    // all requesting: full rotation
    step(4'b0000, 1'b0);
    for (int i = 0; i < 32; i++) step(4'b1111, 1'b1);
    // early release of requester 0, then requester 1 after the gap
    step(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0011, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0010, 1'b1);
    // release coinciding with the last slot cycle counts as timeout
    step(4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    check_val("drop_at_tc_done", 32'(slot_done), 32'd1);
    step(4'b0000, 1'b1);
    // reset in the middle of a grant to requester 2
    step(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b1);
    step(4'b0101, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0101, 1'b1);
    check_val("post_reset_owner", 32'(grant_id), 32'd0);

    // randomized traffic with sticky request levels and rare resets
    r = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) r = NUM_REQ'($urandom_range(0, 15));
      rs = ($urandom_range(0, 149) != 0);
      step(r, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
